// File: rtl/rat_uart_rx_port.sv
// RAT MCU UART receive port: 8N1 receiver feeding a small byte FIFO, read through
// IN_PORT / PORT_ID, popped and flag-cleared by an OUT to POP_ID.
module rat_uart_rx_port #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          DEPTH        = 4,
    parameter logic [7:0]  DATA_ID      = 8'h10,
    parameter logic [7:0]  STATUS_ID    = 8'h11,
    parameter logic [7:0]  POP_ID       = 8'h12
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RX,
    input  logic [7:0] PORT_ID,
    input  logic       IO_STRB,
    input  logic [7:0] OUT_PORT,
    output logic [7:0] IN_PORT_DATA,
    output logic       INTR
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic             rx_meta_q, rxs_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, intr_q, intr_d;

    logic rx_push, rx_ferr;
    logic pop_req, clr_req, pop_en, push_en, ovr_set;
    logic empty, full;
    logic [2:0] cnt_sat;
    logic [7:0] status;
    logic unused_out_bits;

    assign unused_out_bits = ^OUT_PORT[7:2];

    // Receiver: counter restarts at every sample point so START waits half a bit
    // and DATA/STOP land mid-bit thereafter.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rx_push   = 1'b0;
        rx_ferr   = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    state_d   = S_IDLE;
                    rx_push   = rxs_q;
                    rx_ferr   = !rxs_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO and flags. A pop in the same cycle as a push frees the slot, so a
    // full FIFO accepts the new byte without overrun.
    always_comb begin
        pop_req  = IO_STRB && (PORT_ID == POP_ID) && OUT_PORT[0];
        clr_req  = IO_STRB && (PORT_ID == POP_ID) && OUT_PORT[1];
        empty    = (count_q == '0);
        full     = (count_q == DEPTH_C);
        pop_en   = pop_req && !empty;
        push_en  = rx_push && (!full || pop_en);
        ovr_set  = rx_push && full && !pop_en;
        wr_ptr_d = push_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_en  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_en && !pop_en)      count_d = count_q + CW'(1);
        else if (!push_en && pop_en) count_d = count_q - CW'(1);
        ovr_d  = ovr_set ? 1'b1 : (clr_req ? 1'b0 : ovr_q);
        ferr_d = rx_ferr ? 1'b1 : (clr_req ? 1'b0 : ferr_q);
        intr_d = !empty;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            intr_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            intr_q    <= intr_d;
            if (push_en) mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_comb begin
        cnt_sat = (32'(count_q) > 7) ? 3'd7 : 3'(count_q);
        status  = {(state_q != S_IDLE), cnt_sat, ferr_q, ovr_q, full, !empty};
        IN_PORT_DATA = 8'h00;
        if (PORT_ID == DATA_ID)        IN_PORT_DATA = empty ? 8'h00 : mem_q[rd_ptr_q];
        else if (PORT_ID == STATUS_ID) IN_PORT_DATA = status;
    end

    assign INTR = intr_q;

endmodule

// File: doc/rat_uart_rx_port.md
# rat_uart_rx_port

RAT MCU input-side peripheral: receives 8N1 UART serial data, buffers bytes in a small FIFO, and presents them to the MCU through its IN_PORT / PORT_ID read path. The MCU acknowledges consumption by writing to a pop/control port with IO_STRB. It raises INTR while data is pending. It sits in the RAT wrapper on the 50 MHz MCU clock, and its read data is ORed into the wrapper's input mux.

## Interface
- CLKS_PER_BIT, 434, CLK cycles per UART bit (434 gives 115200 baud at 50 MHz); minimum 4.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- DATA_ID, 8'h10, input port ID returning the FIFO head byte.
- STATUS_ID, 8'h11, input port ID returning the status byte.
- POP_ID, 8'h12, output port ID for pop and flag clear.
- CLK  in  1  MCU clock (s_clk_50); all state on rising edge.
- RESET_N  in  1  one clock; reset is asynchronous and active-low.
- RX  in  1  serial input, asynchronous, idles high.
- PORT_ID  in  8  MCU port address.
- IO_STRB  in  1  MCU output strobe, one cycle per OUT instruction.
- OUT_PORT  in  8  MCU output data.
- IN_PORT_DATA  out  8  read data; 8'h00 when PORT_ID matches neither DATA_ID nor STATUS_ID.
- INTR  out  1  registered; high while FIFO is non-empty.

## Operation
- RX passes through a 2-flop synchronizer (reset value 1). All receiver logic uses the synchronized value rxs.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on rxs==0; the bit counter clears.
  - START: after CLKS_PER_BIT/2 cycles (integer division), sample rxs. If 0 -> DATA. If 1 -> IDLE, treated as a glitch with no flag.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into the byte register -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, push the byte. If 0, drop the byte and set FERR. Either way -> IDLE.
- FIFO: DEPTH entries, read/write pointers, count register 0..DEPTH.
  - Push when full and no pop in the same cycle: byte discarded, OVR set.
  - Push and pop in the same cycle: both take effect, count unchanged, no OVR, including when full.
  - Pop when empty: ignored.
- POP_ID write (IO_STRB=1, PORT_ID==POP_ID):
  - OUT_PORT[0]=1 pops the head.
  - OUT_PORT[1]=1 clears OVR and FERR.
  - Both bits may be set in one write.
  - If a set event and a clear land in the same cycle, the set wins.
- DATA read: head byte, or 8'h00 when empty. A read does not pop.
- STATUS byte:
  - [0] not_empty
  - [1] full
  - [2] OVR (sticky)
  - [3] FERR (sticky)
  - [6:4] count, saturates at 7 for DEPTH>7
  - [7] busy (FSM not IDLE)
- IN_PORT_DATA is combinational from PORT_ID and registered state.
- Reset values: FSM IDLE, FIFO empty, OVR=FERR=0, INTR=0, IN_PORT_DATA=8'h00 for unmatched IDs, STATUS=8'h00.

## Timing
- The synchronizer adds 2 cycles. Let T be the cycle rxs first reads 0.
  - Start sample at T+CLKS_PER_BIT/2.
  - Data bit k sampled at T+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - Stop sample at T+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
- The push registers on the stop-sample edge. Count, not_empty and DATA update on the following cycle. INTR rises one cycle after not_empty.
- Pop takes effect on the IO_STRB edge. The new head is visible on the next cycle. INTR falls one cycle after the FIFO empties.
- A new start bit is accepted in the first IDLE cycle after STOP, so back-to-back frames are supported.
- RESET_N low mid-frame aborts the frame immediately. No push, no flags.

## Test plan
- Byte reception (CLKS_PER_BIT=16): send 8'hA5 -> STATUS=8'h11 and DATA=8'hA5 after the stop sample; INTR=1. Then write POP_ID with 8'h01 -> STATUS=8'h00 and INTR=0 two cycles later.
- Overrun: send 5 bytes 8'h01..8'h05 back-to-back with no pops -> STATUS=8'h47 (count 4, full, OVR). Then pop 4 times -> reads return 01, 02, 03, 04. Write 8'h02 -> OVR clears.
- Framing error: send 8'h3C with stop bit 0 -> count stays 0, FERR=1 (STATUS=8'h08). Send 8'h3C correctly -> received, FERR remains set until cleared.
- Glitch and simultaneous push/pop:
  - Pulse RX low for 3 cycles -> FSM returns to IDLE, no push.
  - With FIFO full, issue a pop on the exact stop-sample cycle -> count stays 4, OVR=0, new byte at tail.
- Reset mid-frame: drop RESET_N during DATA bit 4 -> all outputs reset asynchronously. A following frame 8'hFF is received correctly.
- Decode isolation: PORT_ID=8'hFF or 8'h12 on the read path -> IN_PORT_DATA=8'h00. IO_STRB with PORT_ID=8'h40 -> FIFO unchanged.
